// File: rtl/div32_seq_pkg.sv
// div32_seq_pkg: shared types and constants for the sequential 32-bit divider.
//   div_state_e : FSM state encoding (Idle/Busy/Fixup/Done = 0..3)
//   DivIter     : restoring-division iterations per operation
//   DivDzQ      : quotient delivered on divide-by-zero
package div32_seq_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusy  = 2'd1,
    StFixup = 2'd2,
    StDone  = 2'd3
  } div_state_e;

  localparam int unsigned DivIter = 32;
  localparam logic [31:0] DivDzQ  = 32'hFFFF_FFFF;

endpackage

// File: rtl/div32_seq_if.sv
// div32_seq_if: request/result bundle between EX control and the divider.
//   master : drives start, sign, cancel, a, b; observes q, r, busy, ready, dz
//   slave  : the divider side (directions reversed)
interface div32_seq_if #(
  parameter int unsigned Width = 32
) ();
  logic             start;
  logic             sign;
  logic             cancel;
  logic [Width-1:0] a;
  logic [Width-1:0] b;
  logic [Width-1:0] q;
  logic [Width-1:0] r;
  logic             busy;
  logic             ready;
  logic             dz;

  modport master (
    output start, sign, cancel, a, b,
    input  q, r, busy, ready, dz
  );

  modport slave (
    input  start, sign, cancel, a, b,
    output q, r, busy, ready, dz
  );
endinterface

// File: rtl/div32_seq_addsub32.sv
// addsub32: 32-bit adder/subtracter shared with the ALU datapath.
//   i_a, i_b : operands
//   i_sub    : 1 = i_a - i_b, 0 = i_a + i_b
//   o_s      : result (carry-out discarded)
module addsub32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_sub,
  output logic [31:0] o_s
);
  logic [31:0] w_b;

  assign w_b = i_b ^ {32{i_sub}};
  assign o_s = i_a + w_b + {31'd0, i_sub};
endmodule

// File: rtl/div32_seq.sv
// div32_seq: iterative signed/unsigned divider for MIPS DIV/DIVU.
//   i_clk   : rising-edge clock
//   i_rst_n : asynchronous active-low reset
//   io_div  : slave side of div32_seq_if
//             start/sign/a/b sampled in Idle, cancel aborts Busy/Fixup,
//             q (LO) / r (HI) / dz valid from the ready pulse and held.
// One restoring step per cycle on operand magnitudes, then a single fixup
// cycle applies signs using two addsub32 instances as negators.
module div32_seq
  import div32_seq_pkg::*;
#(
  parameter int unsigned Width = 32,
  parameter int unsigned CntW  = 5
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  div32_seq_if.slave io_div
);
  localparam logic [CntW-1:0] LastCnt = CntW'(DivIter - 1);

  div_state_e       r_state, w_state_nxt;
  logic [CntW-1:0]  r_cnt;
  logic [Width-1:0] r_dvd, r_dvs, r_rem, r_quo, r_q, r_r;
  logic             r_sign, r_a_sgn, r_b_sgn, r_dz;
  logic             w_busy, w_ready, w_in_idle, w_neg_q, w_neg_r, w_dz;
  logic [Width:0]   w_trial, w_diff;
  logic [Width-1:0] w_neg0_in, w_neg1_in, w_neg0, w_neg1, w_mag_a, w_mag_b;

  // The negators compute operand magnitudes in Idle and sign-fix results in
  // Fixup; the two uses never overlap.
  assign w_in_idle = (r_state == StIdle);
  assign w_neg0_in = w_in_idle ? io_div.a : r_quo;
  assign w_neg1_in = w_in_idle ? io_div.b : r_rem;

  addsub32 u_neg0 (
    .i_a   (32'd0),
    .i_b   (w_neg0_in),
    .i_sub (1'b1),
    .o_s   (w_neg0)
  );

  addsub32 u_neg1 (
    .i_a   (32'd0),
    .i_b   (w_neg1_in),
    .i_sub (1'b1),
    .o_s   (w_neg1)
  );

  assign w_mag_a = (io_div.sign && io_div.a[Width-1]) ? w_neg0 : io_div.a;
  assign w_mag_b = (io_div.sign && io_div.b[Width-1]) ? w_neg1 : io_div.b;

  assign w_trial = {r_rem, r_dvd[Width-1]};
  assign w_diff  = w_trial - {1'b0, r_dvs};

  assign w_neg_q = r_sign && (r_a_sgn != r_b_sgn);
  assign w_neg_r = r_sign && r_a_sgn;
  // |b| is zero exactly when b is zero.
  assign w_dz    = (r_dvs == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_ready     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (io_div.start && !io_div.cancel) w_state_nxt = StBusy;
      end
      StBusy: begin
        w_busy = 1'b1;
        if (io_div.cancel)        w_state_nxt = StIdle;
        else if (r_cnt == LastCnt) w_state_nxt = StFixup;
      end
      StFixup: begin
        w_busy      = 1'b1;
        w_state_nxt = io_div.cancel ? StIdle : StDone;
      end
      StDone: begin
        w_ready     = 1'b1;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_sign  <= 1'b0;
      r_a_sgn <= 1'b0;
      r_b_sgn <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        StIdle: begin
          if (io_div.start && !io_div.cancel) begin
            r_dvd   <= w_mag_a;
            r_dvs   <= w_mag_b;
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
            r_sign  <= io_div.sign;
            r_a_sgn <= io_div.a[Width-1];
            r_b_sgn <= io_div.b[Width-1];
            r_dz    <= 1'b0;
          end
        end
        StBusy: begin
          if (!io_div.cancel) begin
            r_rem <= w_diff[Width] ? w_trial[Width-1:0] : w_diff[Width-1:0];
            r_quo <= {r_quo[Width-2:0], ~w_diff[Width]};
            r_dvd <= {r_dvd[Width-2:0], 1'b0};
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StFixup: begin
          if (!io_div.cancel) begin
            // With a zero divisor the remainder ends up as |a|, so the normal
            // remainder fixup already restores the raw dividend.
            r_q  <= w_dz ? DivDzQ : (w_neg_q ? w_neg0 : r_quo);
            r_r  <= w_neg_r ? w_neg1 : r_rem;
            r_dz <= w_dz;
          end
        end
        default: ;
      endcase
    end
  end

  assign io_div.q     = r_q;
  assign io_div.r     = r_r;
  assign io_div.dz    = r_dz;
  assign io_div.busy  = w_busy;
  assign io_div.ready = w_ready;
endmodule

// File: tb/tb_div32_seq.sv
// tb_div32_seq: directed self-checking bench for div32_seq.
// Cycle k is the clock period that ends with rising edge k; a start driven
// during cycle 0 is sampled at edge 0. Outputs are sampled on falling edges.
module tb_div32_seq;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  div32_seq_if #(.Width(32)) dif ();

  div32_seq #(
    .Width (32),
    .CntW  (5)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_div  (dif.slave)
  );

  always #5 clk = ~clk;

  // Call from a falling edge; returns just after the sampling edge (cycle 1).
  task automatic do_start(input logic [31:0] a, input logic [31:0] b, input logic s);
    dif.a     = a;
    dif.b     = b;
    dif.sign  = s;
    dif.start = 1'b1;
    @(posedge clk);
    #1 dif.start = 1'b0;
  endtask

  // Returns the cycle number in which ready is seen, or -1 after a bound.
  task automatic wait_ready(input int first, output int cyc);
    cyc = first;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (dif.ready === 1'b1) return;
      cyc++;
    end
    cyc = -1;
  endtask

  task automatic test_reset();
    dif.start = 1'b0; dif.sign = 1'b0; dif.cancel = 1'b0; dif.a = '0; dif.b = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({dif.q, dif.r} !== 64'd0) begin
      failures++; $display("FAIL reset_qr: got %h want 0", {dif.q, dif.r});
    end
    checks++;
    if ({dif.busy, dif.ready, dif.dz} !== 3'b000) begin
      failures++; $display("FAIL reset_flags: got %b want 000", {dif.busy, dif.ready, dif.dz});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    int busy_bad = 0;
    int ready_bad = 0;
    do_start(32'd100, 32'd7, 1'b0);
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      if (dif.busy !== 1'b1) busy_bad++;
      if (dif.ready !== 1'b0) ready_bad++;
    end
    checks++;
    if (busy_bad != 0 || ready_bad != 0) begin
      failures++;
      $display("FAIL unsigned_busy_window: bad busy %0d bad ready %0d want 0 0", busy_bad, ready_bad);
    end
    @(negedge clk);  // cycle 34
    checks++;
    if ({dif.ready, dif.busy} !== 2'b10) begin
      failures++; $display("FAIL unsigned_ready34: got ready/busy %b want 10", {dif.ready, dif.busy});
    end
    checks++;
    if ({dif.q, dif.r, dif.dz} !== {32'd14, 32'd2, 1'b0}) begin
      failures++; $display("FAIL unsigned_100_7: got q=%0d r=%0d dz=%b want 14 2 0", dif.q, dif.r, dif.dz);
    end
    @(negedge clk);
    checks++;
    if (dif.ready !== 1'b0 || dif.q !== 32'd14) begin
      failures++; $display("FAIL unsigned_pulse: got ready=%b q=%0d want 0 14", dif.ready, dif.q);
    end
  endtask

  task automatic test_signed();
    int cyc;
    do_start(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_ready(1, cyc);
    checks++;
    if ({dif.q, dif.r} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF} || cyc != 34) begin
      failures++; $display("FAIL signed_m7_2: got q=%h r=%h cyc=%0d want fffffffd ffffffff 34", dif.q, dif.r, cyc);
    end
    @(negedge clk);
    do_start(32'd7, 32'hFFFF_FFFE, 1'b1);
    wait_ready(1, cyc);
    checks++;
    if ({dif.q, dif.r} !== {32'hFFFF_FFFD, 32'd1} || cyc != 34) begin
      failures++; $display("FAIL signed_7_m2: got q=%h r=%h cyc=%0d want fffffffd 00000001 34", dif.q, dif.r, cyc);
    end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    int cyc;
    do_start(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_ready(1, cyc);
    checks++;
    if ({dif.q, dif.r, dif.dz} !== {32'h8000_0000, 32'd0, 1'b0}) begin
      failures++; $display("FAIL overflow_signed: got q=%h r=%h dz=%b want 80000000 0 0", dif.q, dif.r, dif.dz);
    end
    @(negedge clk);
    do_start(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_ready(1, cyc);
    checks++;
    if ({dif.q, dif.r} !== {32'd0, 32'h8000_0000}) begin
      failures++; $display("FAIL overflow_unsigned: got q=%h r=%h want 0 80000000", dif.q, dif.r);
    end
    @(negedge clk);
  endtask

  task automatic test_div_zero();
    int cyc;
    for (int s = 0; s < 2; s++) begin
      do_start(32'h1234_5678, 32'd0, s[0]);
      wait_ready(1, cyc);
      checks++;
      if ({dif.q, dif.r, dif.dz} !== {32'hFFFF_FFFF, 32'h1234_5678, 1'b1} || cyc != 34) begin
        failures++;
        $display("FAIL div_zero_sign%0d: got q=%h r=%h dz=%b cyc=%0d want ffffffff 12345678 1 34",
                 s, dif.q, dif.r, dif.dz, cyc);
      end
      @(negedge clk);
    end
    do_start(32'hFFFF_FFF8, 32'd0, 1'b1);
    wait_ready(1, cyc);
    checks++;
    if ({dif.q, dif.r, dif.dz} !== {32'hFFFF_FFFF, 32'hFFFF_FFF8, 1'b1}) begin
      failures++; $display("FAIL div_zero_neg_a: got q=%h r=%h dz=%b want ffffffff fffffff8 1", dif.q, dif.r, dif.dz);
    end
    @(negedge clk);
    do_start(32'd100, 32'd7, 1'b0);
    wait_ready(1, cyc);
    checks++;
    if ({dif.q, dif.r, dif.dz} !== {32'd14, 32'd2, 1'b0}) begin
      failures++; $display("FAIL div_zero_clear: got q=%0d r=%0d dz=%b want 14 2 0", dif.q, dif.r, dif.dz);
    end
    @(negedge clk);
  endtask

  task automatic test_cancel();
    int cyc;
    int ready_seen = 0;
    do_start(32'd100, 32'd7, 1'b0);
    wait_ready(1, cyc);
    @(negedge clk);
    do_start(32'd5000, 32'd9, 1'b0);         // cycle 1 now
    repeat (9) begin
      @(posedge clk);
      #1 if (dif.ready) ready_seen++;
    end                                      // cycle 10 now
    dif.cancel = 1'b1;
    @(negedge clk);
    checks++;
    if (dif.busy !== 1'b1) begin
      failures++; $display("FAIL cancel_busy10: got %b want 1", dif.busy);
    end
    @(posedge clk);
    #1 dif.cancel = 1'b0;
    @(negedge clk);                          // cycle 11
    if (dif.ready) ready_seen++;
    checks++;
    if (dif.busy !== 1'b0) begin
      failures++; $display("FAIL cancel_busy11: got %b want 0", dif.busy);
    end
    @(negedge clk);                          // cycle 12
    if (dif.ready) ready_seen++;
    checks++;
    if ({dif.q, dif.r} !== {32'd14, 32'd2} || ready_seen != 0) begin
      failures++; $display("FAIL cancel_hold: got q=%0d r=%0d readys=%0d want 14 2 0", dif.q, dif.r, ready_seen);
    end
    do_start(32'd1000, 32'd3, 1'b0);          // sampled at edge 12, now cycle 13
    wait_ready(13, cyc);
    checks++;
    if ({dif.q, dif.r} !== {32'd333, 32'd1} || cyc != 46) begin
      failures++; $display("FAIL cancel_restart: got q=%0d r=%0d cyc=%0d want 333 1 46", dif.q, dif.r, cyc);
    end
    @(negedge clk);
  endtask

  task automatic test_start_while_busy();
    int cyc;
    do_start(32'd1000, 32'd7, 1'b0);          // cycle 1
    repeat (4) @(posedge clk);               // cycle 5
    #1;
    dif.a = 32'd5; dif.b = 32'd1; dif.start = 1'b1;
    @(posedge clk);
    #1 dif.start = 1'b0;                     // cycle 6
    wait_ready(6, cyc);
    checks++;
    if ({dif.q, dif.r} !== {32'd142, 32'd6} || cyc != 34) begin
      failures++; $display("FAIL start_busy: got q=%0d r=%0d cyc=%0d want 142 6 34", dif.q, dif.r, cyc);
    end
    @(negedge clk);
    checks++;
    if (dif.busy !== 1'b0) begin
      failures++; $display("FAIL start_busy_queued: got busy=%b want 0", dif.busy);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    do_start(32'd1000, 32'd3, 1'b0);
    wait_ready(1, cyc);
    @(negedge clk);                          // ready + 1
    do_start(32'hFFFF_FFFF, 32'h10, 1'b0);
    wait_ready(1, cyc);
    checks++;
    if ({dif.q, dif.r} !== {32'h0FFF_FFFF, 32'hF} || cyc != 34) begin
      failures++; $display("FAIL back_to_back: got q=%h r=%h cyc=%0d want 0fffffff f 34", dif.q, dif.r, cyc);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    do_start(32'd77, 32'd5, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({dif.q, dif.r, dif.busy, dif.ready, dif.dz} !== 67'd0) begin
      failures++;
      $display("FAIL async_reset: got q=%h r=%h busy=%b ready=%b dz=%b want all 0",
               dif.q, dif.r, dif.busy, dif.ready, dif.dz);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_overflow();
    test_div_zero();
    test_cancel();
    test_start_while_busy();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
